nmea_sentence_parser: RTL
=========================

Name: nmea_sentence_parser

Overview:
Generic, parametrised NMEA-0183 sentence parser. It sits between the GPS UART receive byte stream and the navigation logic. It accepts one configurable sentence ID (GPGGA by default), splits the comma-separated fields into a shadow buffer and verifies the XOR checksum. Only checksum-valid sentences are committed atomically to an output bank, which is read through a field-select port.

Parameters:
SENTENCE_ID, "GPGGA" (40 bits, 5 ASCII chars), sentence header to accept; any other header is silently dropped.
MAX_FIELDS, 16, maximum data fields stored after the header.
FIELD_LEN, 12, maximum characters per field.
TIMEOUT_CYCLES, 1_000_000, idle sclk cycles mid-sentence before abort; 0 disables the timeout.

Ports:
sclk  input  1  system clock.
rstn  input  1  asynchronous active-low reset.
dataByte  input  8  received ASCII byte.
dataReady  input  1  one-cycle strobe; dataByte is valid this cycle.
fieldSel  input  $clog2(MAX_FIELDS)  field index to read (0 = first field after header).
fieldData  output  8*FIELD_LEN  selected committed field; first char in MS byte, unused bytes 0.
fieldLen  output  $clog2(FIELD_LEN+1)  character count of the selected field.
fieldCount  output  $clog2(MAX_FIELDS+1)  number of fields in the last committed sentence.
sentenceValid  output  1  one-cycle pulse when a new sentence is committed.
checksumErr  output  1  one-cycle pulse on checksum mismatch.
formatErr  output  1  one-cycle pulse on overflow, bad character or timeout.
busy  output  1  high while the state is not IDLE.
GPSReady  output  1  sticky; set on the first commit, cleared only by reset.

Behaviour:
- Reset (async, rstn=0): state IDLE. All outputs 0. Output bank, shadow bank, fieldCount, checksum accumulator and timeout counter all 0.
- States:
  - IDLE: '$' -> HEADER. All other bytes, including CR and LF, are ignored.
  - HEADER: 5 chars are compared with SENTENCE_ID, then ',' is required.
    - Match -> FIELD, field index 0.
    - Mismatch -> IDLE, with no error pulse.
    - Non-',' after 5 chars -> formatErr, IDLE.
  - FIELD:
    - ',' -> close the field, index+1.
    - '*' -> close the field, go to CSUM_HI.
    - Any other byte -> append to the current field.
  - CSUM_HI, CSUM_LO: two hex digits, 0-9 / A-F / a-f; a non-hex byte -> formatErr, IDLE.
  - EOL: CR (0x0D) required.
    - Match -> commit.
    - Mismatch -> checksumErr, IDLE.
    - Non-CR byte -> formatErr, IDLE.
- Checksum: 8-bit XOR of every byte strictly between '$' and '*'. The accumulator clears on '$'.
- Field count: fieldCount = number of closed fields, i.e. (commas after the header) + 1. Empty fields have fieldLen 0 and are counted.
- Overflow:
  - A FIELD_LEN+1-th char in one field -> formatErr, IDLE.
  - Opening field index MAX_FIELDS -> formatErr, IDLE.
  - The output bank is untouched in both cases.
- Resync: '$' in any non-IDLE state aborts the current sentence with no error pulse, restarts HEADER and clears the shadow bank.
- Timeout: the counter clears on every dataReady. If it reaches TIMEOUT_CYCLES in a non-IDLE state -> formatErr, IDLE.
- Commit latency: on the sclk edge that samples a matching CR:
  - shadow bank -> output bank, and fieldCount is updated;
  - sentenceValid=1 for exactly that following cycle;
  - GPSReady is set.
- Failed sentences: no partial or failed sentence ever alters the output bank.
- Read path: fieldData and fieldLen are combinational from the output bank and fieldSel. A fieldSel >= fieldCount returns 0 and 0.
- Strobe rules:
  - Bytes are processed only on dataReady=1.
  - dataReady is assumed to be at most one cycle wide per byte; back-to-back strobes on consecutive cycles are supported.
- Error pulses: at most one of sentenceValid, checksumErr, formatErr pulses per cycle.

Test Plan:
1. Valid sentence: stream "$GPGGA,123519,4807.038,N,01131.000,E,1,08,0.9,545.4,M,46.9,M,,*47\r\n" -> one sentenceValid pulse and GPSReady=1. Also:
   - fieldCount=14;
   - fieldSel=0 gives fieldData "123519" left-justified, fieldLen=6;
   - fieldSel=1 gives "4807.038", fieldLen=8;
   - fieldSel=12 and 13 give fieldLen=0;
   - fieldSel=14 gives 0.
2. Bad checksum: the same sentence with "*48" -> checksumErr pulse, no sentenceValid, and the output bank still holds the sentence from test 1.
3. Wrong ID and resync: stream "$GPRMC,..." then "$GPG$GPGGA,..." (valid) -> GPRMC dropped with no error pulse, and the second sentence is committed.
4. Overflow: a field of 13 chars with FIELD_LEN=12 -> formatErr, IDLE, output bank unchanged. Also run 17 fields with MAX_FIELDS=16 -> formatErr.
5. Timeout: with TIMEOUT_CYCLES=100, stop the stream after "$GPGGA,12" -> formatErr exactly 100 cycles after the last strobe, busy=0.
6. Reset mid-sentence: assert rstn=0 asynchronously during FIELD -> all outputs 0 immediately. A following valid sentence then commits normally.

Source files
------------

// File: rtl/nmea_sentence_parser.sv
// NMEA-0183 sentence parser: splits one sentence type into fields and checks the XOR sum.
// Fields build up in a shadow bank and reach the output bank only on a good CR.
module nmea_sentence_parser #(
    parameter logic [39:0] SENTENCE_ID    = "GPGGA",
    parameter int          MAX_FIELDS     = 16,
    parameter int          FIELD_LEN      = 12,
    parameter int          TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                            sclk,
    input  logic                            rstn,
    input  logic [7:0]                      dataByte,
    input  logic                            dataReady,
    input  logic [$clog2(MAX_FIELDS)-1:0]   fieldSel,
    output logic [8*FIELD_LEN-1:0]          fieldData,
    output logic [$clog2(FIELD_LEN+1)-1:0]  fieldLen,
    output logic [$clog2(MAX_FIELDS+1)-1:0] fieldCount,
    output logic                            sentenceValid,
    output logic                            checksumErr,
    output logic                            formatErr,
    output logic                            busy,
    output logic                            GPSReady
);
    localparam int SW = $clog2(MAX_FIELDS);
    localparam int LW = $clog2(FIELD_LEN + 1);
    localparam int CW = $clog2(MAX_FIELDS + 1);
    localparam int FW = 8 * FIELD_LEN;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST =
        TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE, S_HEADER, S_FIELD, S_CSUM_HI, S_CSUM_LO, S_EOL
    } state_t;

    state_t        state;
    logic [2:0]    hdr_cnt;
    logic          hdr_bad;
    logic [SW-1:0] idx;
    logic [LW-1:0] len;
    logic [7:0]    csum_acc;
    logic [7:0]    csum_rx;
    logic [TW-1:0] to_cnt;
    logic [7:0]    id_char;
    logic [4:0]    hex;
    logic          sel_ok;

    logic [FW-1:0] sh_data  [MAX_FIELDS];
    logic [LW-1:0] sh_len   [MAX_FIELDS];
    logic [FW-1:0] out_data [MAX_FIELDS];
    logic [LW-1:0] out_len  [MAX_FIELDS];

    // bit 4 marks a legal hex digit, bits 3:0 carry its value
    function automatic logic [4:0] hex_val(input logic [7:0] c);
        if (c >= "0" && c <= "9") return {1'b1, c[3:0]};
        if ((c >= "A" && c <= "F") || (c >= "a" && c <= "f"))
            return {1'b1, c[3:0] + 4'd9};
        return 5'd0;
    endfunction

    always_comb begin
        case (hdr_cnt)
            3'd0:    id_char = SENTENCE_ID[39:32];
            3'd1:    id_char = SENTENCE_ID[31:24];
            3'd2:    id_char = SENTENCE_ID[23:16];
            3'd3:    id_char = SENTENCE_ID[15:8];
            3'd4:    id_char = SENTENCE_ID[7:0];
            default: id_char = 8'h00;
        endcase
    end

    assign hex       = hex_val(dataByte);
    assign sel_ok    = CW'(fieldSel) < fieldCount;
    assign fieldData = sel_ok ? out_data[fieldSel] : '0;
    assign fieldLen  = sel_ok ? out_len[fieldSel] : '0;
    assign busy      = (state != S_IDLE);

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            state         <= S_IDLE;
            hdr_cnt       <= '0;
            hdr_bad       <= 1'b0;
            idx           <= '0;
            len           <= '0;
            csum_acc      <= '0;
            csum_rx       <= '0;
            to_cnt        <= '0;
            fieldCount    <= '0;
            sentenceValid <= 1'b0;
            checksumErr   <= 1'b0;
            formatErr     <= 1'b0;
            GPSReady      <= 1'b0;
            for (int i = 0; i < MAX_FIELDS; i++) begin
                sh_data[i]  <= '0;
                sh_len[i]   <= '0;
                out_data[i] <= '0;
                out_len[i]  <= '0;
            end
        end else begin
            sentenceValid <= 1'b0;
            checksumErr   <= 1'b0;
            formatErr     <= 1'b0;
            if (dataReady) begin
                to_cnt <= '0;
                if (dataByte == "$") begin
                    // '$' always (re)starts a sentence, silently dropping any partial one
                    state    <= S_HEADER;
                    hdr_cnt  <= '0;
                    hdr_bad  <= 1'b0;
                    idx      <= '0;
                    len      <= '0;
                    csum_acc <= '0;
                    for (int i = 0; i < MAX_FIELDS; i++) begin
                        sh_data[i] <= '0;
                        sh_len[i]  <= '0;
                    end
                end else begin
                    unique case (state)
                        S_IDLE: ;
                        S_HEADER: begin
                            csum_acc <= csum_acc ^ dataByte;
                            if (hdr_cnt == 3'd5) begin
                                if (dataByte == ",") begin
                                    state <= S_FIELD;
                                end else begin
                                    formatErr <= 1'b1;
                                    state     <= S_IDLE;
                                end
                            end else begin
                                hdr_cnt <= hdr_cnt + 3'd1;
                                if (hdr_cnt == 3'd4 && (hdr_bad || dataByte != id_char))
                                    state <= S_IDLE;
                                else if (dataByte != id_char)
                                    hdr_bad <= 1'b1;
                            end
                        end
                        S_FIELD: begin
                            if (dataByte == "*") begin
                                state <= S_CSUM_HI;
                            end else begin
                                csum_acc <= csum_acc ^ dataByte;
                                if (dataByte == ",") begin
                                    if (idx == SW'(MAX_FIELDS - 1)) begin
                                        formatErr <= 1'b1;
                                        state     <= S_IDLE;
                                    end else begin
                                        idx <= idx + 1'b1;
                                        len <= '0;
                                    end
                                end else if (len == LW'(FIELD_LEN)) begin
                                    formatErr <= 1'b1;
                                    state     <= S_IDLE;
                                end else begin
                                    sh_data[idx][FW-8-8*int'(len) +: 8] <= dataByte;
                                    sh_len[idx] <= len + 1'b1;
                                    len         <= len + 1'b1;
                                end
                            end
                        end
                        S_CSUM_HI: begin
                            if (hex[4]) begin
                                csum_rx[7:4] <= hex[3:0];
                                state        <= S_CSUM_LO;
                            end else begin
                                formatErr <= 1'b1;
                                state     <= S_IDLE;
                            end
                        end
                        S_CSUM_LO: begin
                            if (hex[4]) begin
                                csum_rx[3:0] <= hex[3:0];
                                state        <= S_EOL;
                            end else begin
                                formatErr <= 1'b1;
                                state     <= S_IDLE;
                            end
                        end
                        S_EOL: begin
                            state <= S_IDLE;
                            if (dataByte != 8'h0D) begin
                                formatErr <= 1'b1;
                            end else if (csum_rx != csum_acc) begin
                                checksumErr <= 1'b1;
                            end else begin
                                out_data      <= sh_data;
                                out_len       <= sh_len;
                                fieldCount    <= CW'(idx) + CW'(1);
                                sentenceValid <= 1'b1;
                                GPSReady      <= 1'b1;
                            end
                        end
                        default: state <= S_IDLE;
                    endcase
                end
            end else if (state != S_IDLE && TIMEOUT_CYCLES != 0) begin
                if (to_cnt == TO_LAST) begin
                    formatErr <= 1'b1;
                    state     <= S_IDLE;
                    to_cnt    <= '0;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end
        end
    end
endmodule
